// File: rtl/byte_bus_arbiter_pkg.sv
// rtl/byte_bus_arbiter_pkg.sv - shared types and constants for the byte bus arbiter
package byte_bus_pkg;

  localparam int DW_DEFAULT = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'b001,
    ST_OWN_A = 3'b010,
    ST_OWN_B = 3'b100
  } state_e;

  localparam logic OWNER_A = 1'b1;
  localparam logic OWNER_B = 1'b0;

endpackage

// File: rtl/byte_bus_arbiter_mux.sv
// rtl/byte_bus_arbiter_mux.sv - 8-bit 2:1 byte mux shared by both requesters
module MUX1 #(
  parameter int W = 8
) (
  input  logic [W-1:0] ina,
  input  logic [W-1:0] inb,
  input  logic         sel,
  output logic [W-1:0] y
);

  assign y = sel ? ina : inb;

endmodule

// File: rtl/byte_bus_arbiter.sv
// rtl/byte_bus_arbiter.sv - round-robin two-requester arbiter with bounded hold
// driving the shared byte mux and a registered shared bus.
module byte_bus_arbiter
  import byte_bus_pkg::*;
#(
  parameter int DW       = DW_DEFAULT,
  parameter int MAX_HOLD = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_a,
  input  logic          req_b,
  input  logic [DW-1:0] din_a,
  input  logic [DW-1:0] din_b,
  output logic          gnt_a,
  output logic          gnt_b,
  output logic          sel,
  output logic [DW-1:0] bus_out,
  output logic          bus_valid
);

  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

  state_e        state_q, state_d;
  logic          last_owner_q, last_owner_d;
  logic [3:0]    hold_cnt_q, hold_cnt_d;

  logic          gnt_a_q, gnt_b_q, sel_q, bus_valid_q;
  logic [DW-1:0] bus_out_q;
  logic [DW-1:0] mux_y;
  logic          capture;

  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    hold_cnt_d   = hold_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req_a && req_b)
          state_d = (last_owner_q == OWNER_A) ? ST_OWN_B : ST_OWN_A;
        else if (req_a)
          state_d = ST_OWN_A;
        else if (req_b)
          state_d = ST_OWN_B;
      end
      ST_OWN_A: begin
        // Release takes priority over preemption when both happen together.
        if (!req_a)
          state_d = req_b ? ST_OWN_B : ST_IDLE;
        else if (req_b && hold_cnt_q == HOLD_LAST)
          state_d = ST_OWN_B;
        else if (req_b)
          hold_cnt_d = hold_cnt_q + 4'd1;
      end
      ST_OWN_B: begin
        if (!req_b)
          state_d = req_a ? ST_OWN_A : ST_IDLE;
        else if (req_a && hold_cnt_q == HOLD_LAST)
          state_d = ST_OWN_A;
        else if (req_a)
          hold_cnt_d = hold_cnt_q + 4'd1;
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_d != state_q)
      hold_cnt_d = '0;
    if (state_d == ST_OWN_A && state_q != ST_OWN_A)
      last_owner_d = OWNER_A;
    if (state_d == ST_OWN_B && state_q != ST_OWN_B)
      last_owner_d = OWNER_B;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_owner_q <= OWNER_B;
      hold_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      hold_cnt_q   <= hold_cnt_d;
    end
  end

  MUX1 #(.W(DW)) u_mux (
    .ina (din_a),
    .inb (din_b),
    .sel (sel_q),
    .y   (mux_y)
  );

  // A byte moves only while the current owner still asserts its request.
  assign capture = (gnt_a_q && req_a) || (gnt_b_q && req_b);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_a_q     <= 1'b0;
      gnt_b_q     <= 1'b0;
      sel_q       <= 1'b0;
      bus_valid_q <= 1'b0;
      bus_out_q   <= '0;
    end else begin
      gnt_a_q     <= (state_d == ST_OWN_A);
      gnt_b_q     <= (state_d == ST_OWN_B);
      sel_q       <= (state_d == ST_OWN_A);
      bus_valid_q <= capture;
      if (capture)
        bus_out_q <= mux_y;
    end
  end

  assign gnt_a     = gnt_a_q;
  assign gnt_b     = gnt_b_q;
  assign sel       = sel_q;
  assign bus_out   = bus_out_q;
  assign bus_valid = bus_valid_q;

endmodule

// File: tb/tb_byte_bus_arbiter.sv
// tb/tb_byte_bus_arbiter.sv - directed self-checking bench for byte_bus_arbiter
module tb_byte_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_a, req_b;
  logic [7:0] din_a, din_b;
  logic       gnt_a, gnt_b, sel, bus_valid;
  logic [7:0] bus_out;

  int checks   = 0;
  int failures = 0;

  byte_bus_arbiter #(.DW(8), .MAX_HOLD(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_a     (req_a),
    .req_b     (req_b),
    .din_a     (din_a),
    .din_b     (din_b),
    .gnt_a     (gnt_a),
    .gnt_b     (gnt_b),
    .sel       (sel),
    .bus_out   (bus_out),
    .bus_valid (bus_valid)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_a = 1'b0; req_b = 1'b0;
    din_a = 8'h00; din_b = 8'h00;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({gnt_a, gnt_b, sel, bus_valid, bus_out} !== 12'h000) begin
      failures++;
      $display("FAIL reset_values got=%0h exp=0", {gnt_a, gnt_b, sel, bus_valid, bus_out});
    end
    req_a = 1'b1; din_a = 8'h76;
    step();
    din_a = 8'h77;
    step();
    checks++;
    if (bus_valid !== 1'b1 || bus_out !== 8'h77 || sel !== 1'b1) begin
      failures++;
      $display("FAIL reset_prestream got v=%0b d=%0h s=%0b exp v=1 d=77 s=1", bus_valid, bus_out, sel);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({gnt_a, gnt_b, sel, bus_valid, bus_out} !== 12'h000) begin
      failures++;
      $display("FAIL reset_async got=%0h exp=0", {gnt_a, gnt_b, sel, bus_valid, bus_out});
    end
    step();
    rst = 1'b0;
    req_b = 1'b1;
    step();
    checks++;
    if (gnt_a !== 1'b1 || gnt_b !== 1'b0) begin
      failures++;
      $display("FAIL reset_first_tie got a=%0b b=%0b exp a=1 b=0", gnt_a, gnt_b);
    end
    req_a = 1'b0; req_b = 1'b0;
    step();
    step();
  endtask

  task automatic test_single_owner();
    int nvalid = 0;
    do_reset();
    req_a = 1'b1; din_a = 8'h11;
    step();
    checks++;
    if (gnt_a !== 1'b1 || sel !== 1'b1 || bus_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_grant got g=%0b s=%0b v=%0b exp 1 1 0", gnt_a, sel, bus_valid);
    end
    for (int i = 0; i < 5; i++) begin
      din_a = 8'h11 + 8'(i);
      step();
      if (bus_valid === 1'b1) nvalid++;
      checks++;
      if (bus_out !== 8'h11 + 8'(i) || sel !== 1'b1) begin
        failures++;
        $display("FAIL single_byte%0d got d=%0h s=%0b exp d=%0h s=1", i, bus_out, sel, 8'h11 + 8'(i));
      end
    end
    req_a = 1'b0;
    step();
    if (bus_valid === 1'b1) nvalid++;
    checks++;
    if (nvalid != 5 || gnt_a !== 1'b0 || bus_out !== 8'h15) begin
      failures++;
      $display("FAIL single_count got n=%0d g=%0b d=%0h exp n=5 g=0 d=15", nvalid, gnt_a, bus_out);
    end
  endtask

  task automatic test_tie_round_robin();
    do_reset();
    req_a = 1'b1; req_b = 1'b1; din_a = 8'hA1;
    step();
    checks++;
    if (gnt_a !== 1'b1 || gnt_b !== 1'b0) begin
      failures++;
      $display("FAIL tie1_grant got a=%0b b=%0b exp a=1 b=0", gnt_a, gnt_b);
    end
    req_b = 1'b0;
    step();
    din_a = 8'hA2;
    checks++;
    if (bus_valid !== 1'b1 || bus_out !== 8'hA1) begin
      failures++;
      $display("FAIL tie1_byte0 got v=%0b d=%0h exp v=1 d=a1", bus_valid, bus_out);
    end
    step();
    checks++;
    if (bus_valid !== 1'b1 || bus_out !== 8'hA2) begin
      failures++;
      $display("FAIL tie1_byte1 got v=%0b d=%0h exp v=1 d=a2", bus_valid, bus_out);
    end
    req_a = 1'b0;
    step();
    req_a = 1'b1; req_b = 1'b1; din_b = 8'hB1;
    step();
    checks++;
    if (gnt_a !== 1'b0 || gnt_b !== 1'b1 || sel !== 1'b0) begin
      failures++;
      $display("FAIL tie2_grant got a=%0b b=%0b s=%0b exp a=0 b=1 s=0", gnt_a, gnt_b, sel);
    end
    req_a = 1'b0;
    step();
    din_b = 8'hB2;
    checks++;
    if (bus_valid !== 1'b1 || bus_out !== 8'hB1) begin
      failures++;
      $display("FAIL tie2_byte0 got v=%0b d=%0h exp v=1 d=b1", bus_valid, bus_out);
    end
    step();
    checks++;
    if (bus_valid !== 1'b1 || bus_out !== 8'hB2) begin
      failures++;
      $display("FAIL tie2_byte1 got v=%0b d=%0h exp v=1 d=b2", bus_valid, bus_out);
    end
    req_b = 1'b0;
    step();
  endtask

  task automatic test_preemption();
    do_reset();
    req_a = 1'b1; din_a = 8'h20;
    step();
    step();
    req_b = 1'b1; din_b = 8'hB0;
    for (int i = 1; i <= 4; i++) begin
      din_a = 8'h20 + 8'(i);
      step();
      checks++;
      if (bus_valid !== 1'b1 || bus_out !== 8'h20 + 8'(i) || gnt_a !== (i < 4) || gnt_b !== (i == 4)) begin
        failures++;
        $display("FAIL preempt_cyc%0d got v=%0b d=%0h a=%0b b=%0b exp v=1 d=%0h a=%0b b=%0b",
                 i, bus_valid, bus_out, gnt_a, gnt_b, 8'h20 + 8'(i), (i < 4), (i == 4));
      end
    end
    step();
    checks++;
    if (bus_valid !== 1'b1 || bus_out !== 8'hB0) begin
      failures++;
      $display("FAIL preempt_b_byte got v=%0b d=%0h exp v=1 d=b0", bus_valid, bus_out);
    end
    req_b = 1'b0; din_a = 8'h2F;
    step();
    checks++;
    if (gnt_a !== 1'b1 || gnt_b !== 1'b0) begin
      failures++;
      $display("FAIL preempt_regrant got a=%0b b=%0b exp a=1 b=0", gnt_a, gnt_b);
    end
    step();
    checks++;
    if (bus_valid !== 1'b1 || bus_out !== 8'h2F) begin
      failures++;
      $display("FAIL preempt_a_resume got v=%0b d=%0h exp v=1 d=2f", bus_valid, bus_out);
    end
    req_a = 1'b0;
    step();
  endtask

  task automatic test_release_handover();
    do_reset();
    req_a = 1'b1;
    step();
    req_b = 1'b1; din_a = 8'h40;
    step();
    req_a = 1'b0; din_b = 8'h5C;
    step();
    checks++;
    if (gnt_a !== 1'b0 || gnt_b !== 1'b1 || sel !== 1'b0 || bus_valid !== 1'b0) begin
      failures++;
      $display("FAIL handover_swap got a=%0b b=%0b s=%0b v=%0b exp 0 1 0 0", gnt_a, gnt_b, sel, bus_valid);
    end
    step();
    checks++;
    if (bus_valid !== 1'b1 || bus_out !== 8'h5C) begin
      failures++;
      $display("FAIL handover_byte got v=%0b d=%0h exp v=1 d=5c", bus_valid, bus_out);
    end
    req_b = 1'b0;
    step();
  endtask

  task automatic test_lone_owner();
    int nvalid = 0;
    int bad = 0;
    do_reset();
    req_b = 1'b1;
    step();
    for (int i = 0; i < 20; i++) begin
      din_b = 8'h60 + 8'(i);
      step();
      if (bus_valid === 1'b1) nvalid++;
      if (bus_out !== 8'h60 + 8'(i) || gnt_b !== 1'b1 || dut.hold_cnt_q !== 4'd0) bad++;
    end
    req_b = 1'b0;
    step();
    checks++;
    if (nvalid != 20 || bad != 0) begin
      failures++;
      $display("FAIL lone_owner got valid=%0d bad=%0d exp valid=20 bad=0", nvalid, bad);
    end
    checks++;
    if (bus_valid !== 1'b0 || gnt_b !== 1'b0) begin
      failures++;
      $display("FAIL lone_release got v=%0b b=%0b exp 0 0", bus_valid, gnt_b);
    end
  endtask

  task automatic test_glitch();
    do_reset();
    req_b = 1'b1;
    #3;
    req_b = 1'b0;
    step();
    checks++;
    if (gnt_a !== 1'b0 || gnt_b !== 1'b0) begin
      failures++;
      $display("FAIL glitch_ignored got a=%0b b=%0b exp 0 0", gnt_a, gnt_b);
    end
  endtask

  initial begin
    rst = 1'b1;
    req_a = 1'b0; req_b = 1'b0;
    din_a = 8'h00; din_b = 8'h00;
    test_reset();
    test_single_owner();
    test_tie_round_robin();
    test_preemption();
    test_release_handover();
    test_lone_owner();
    test_glitch();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/byte_bus_arbiter.md
# byte_bus_arbiter

Two-requester arbiter that shares the 8-bit 2:1 byte mux in the 16-bit microprocessor datapath between requester A and requester B. It drives the mux select and a registered 8-bit shared bus. It grants ownership with round-robin fairness and enforces a bounded hold time, so neither side can starve the other. It sits between the two byte sources and the consumer of the shared bus.

## Interface
Parameters:
- DW, 8, data width; must match the mux width.
- MAX_HOLD, 4, maximum consecutive owned cycles while the other side is requesting; legal range 1..15.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_a  in  1  A requests the bus; held high for the whole transfer.
- req_b  in  1  B requests the bus.
- din_a  in  DW  A data; valid whenever req_a and gnt_a are both high.
- din_b  in  DW  B data.
- gnt_a  out  1  registered; A owns the bus.
- gnt_b  out  1  registered; B owns the bus.
- sel  out  1  registered mux select; 1 selects A, 0 selects B; equals gnt_a.
- bus_out  out  DW  registered shared-bus data.
- bus_valid  out  1  registered; bus_out holds a transferred byte this cycle.

## Operation
- States: IDLE, OWN_A, OWN_B, encoded one-hot. gnt_a is 1 only in OWN_A; gnt_b is 1 only in OWN_B. gnt_a and gnt_b are never both 1.
- IDLE transitions:
  - Only req_a high -> OWN_A.
  - Only req_b high -> OWN_B.
  - Both high -> the side opposite last_owner.
  - Neither high -> stay in IDLE.
- OWN_X, release: req_X low -> OWN_other if req_other is high, else IDLE.
- OWN_X, preemption: req_X high and req_other high with hold_cnt == MAX_HOLD-1 -> OWN_other.
  - Requester X loses its grant without notice and must keep req_X high to regain it.
- OWN_X, otherwise: stay in OWN_X.
- last_owner updates to X on every entry into OWN_X.
- hold_cnt:
  - Clears on every state change.
  - Increments each cycle in OWN_X while req_other is high.
  - Holds while req_other is low, so a lone owner keeps the bus indefinitely.
- Data path: the mux output, selected by the registered sel, is captured into bus_out at each edge where the current owner's req and gnt are both high. bus_valid is 1 on the following cycle; otherwise bus_valid is 0 and bus_out holds its last value.
- A req dropping in the same cycle as a preemption is treated as a release; same next state, no difference visible on the outputs.

## Timing
- Reset values: state IDLE, gnt_a 0, gnt_b 0, sel 0, bus_out 0, bus_valid 0, last_owner B (so A wins the first tie), hold_cnt 0.
- Grant latency: req seen high at edge k (from IDLE) -> gnt high after edge k.
- Data latency: first din captured at edge k+1 -> bus_valid high after k+1. Total latency is 2 cycles from req to the first valid byte.
- Handover: gnt_X falls and gnt_other rises on the same edge, with no idle cycle. bus_valid stays high continuously across a handover when both sides are streaming.
- Byte count: a transfer in which req_X stays high for N cycles after the grant produces N valid bytes, one per cycle.
- Reset mid-transfer: all outputs return to reset values immediately and asynchronously. The in-flight byte is discarded and is not replayed.
- Req glitch while not granted: ignored unless the req is high at a sampling edge.

## Structure
- Shared package (byte_bus_pkg):
  - DW default.
  - One-hot state typedef/localparams: ST_IDLE, ST_OWN_A, ST_OWN_B.
  - OWNER_A/OWNER_B constants.
- Data path: instantiate the existing 8-bit 2:1 mux MUX1, with ina=din_a, inb=din_b and sel driven from the registered sel. Do not add a second mux.
- Control: FSM, hold counter and last_owner in one always block with async reset. Output registers in a separate block.

## Test plan
- Reset: assert rst mid-stream with A owning -> gnt_a, sel, bus_valid and bus_out all read 0 in the same cycle; the first tie after deassertion is won by A.
- Single owner: req_a high for 5 cycles, din_a=0x11..0x15 -> gnt_a after 1 edge; bus_out = 0x11..0x15 with bus_valid high for exactly 5 cycles; sel=1 throughout.
- Tie round-robin: req_a and req_b rise together from IDLE twice, each transfer 2 bytes (A 0xA1 0xA2, B 0xB1 0xB2) -> first grant to A; on the second tie the grant goes to B, because last_owner is A.
- Preemption, MAX_HOLD=4: A holds req continuously, B raises req on A's 2nd owned cycle -> gnt_b rises after 4 contested A cycles; bus_valid shows no gap; A is regranted once B releases.
- Release handover: A drops req while B is requesting -> gnt_a and gnt_b swap on the same edge; B's first byte 0x5C appears on bus_out one cycle later.
- Lone owner: B is granted, with req_b high for 20 cycles and req_a low -> no preemption; hold_cnt stays 0; 20 valid bytes.
